// File: rtl/mc_ctrl_if.sv
// Control/handshake bundle between the mc_ctrl sequencer and the MIPS-subset datapath.
// master = sequencer side, slave = datapath/memory side.
interface mc_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic             run;
  logic [5:0]       opcode;
  logic [5:0]       funct;
  logic             eq_zero;
  logic             imem_ready;
  logic             dmem_ready;
  logic             imem_req;
  logic             ir_write;
  logic             pc_write;
  logic [1:0]       pc_src;
  logic             dmem_read;
  logic             dmem_write;
  logic             reg_write;
  logic             reg_dest;
  logic             mem_to_reg;
  logic             alu_src;
  logic [2:0]       alu_ctrl;
  logic [3:0]       state;
  logic             retire;
  logic [CNT_W-1:0] retire_cnt;
  logic             illegal;

  modport master (
    input  run, opcode, funct, eq_zero, imem_ready, dmem_ready,
    output imem_req, ir_write, pc_write, pc_src, dmem_read, dmem_write, reg_write, reg_dest,
           mem_to_reg, alu_src, alu_ctrl, state, retire, retire_cnt, illegal
  );

  modport slave (
    output run, opcode, funct, eq_zero, imem_ready, dmem_ready,
    input  imem_req, ir_write, pc_write, pc_src, dmem_read, dmem_write, reg_write, reg_dest,
           mem_to_reg, alu_src, alu_ctrl, state, retire, retire_cnt, illegal
  );
endinterface

// File: rtl/mc_ctrl.sv
// Multi-cycle control sequencer for the MIPS-subset datapath: fetch/decode/execute FSM
// with inst/data memory handshakes, retired-instruction counter and sticky illegal flag.
module mc_ctrl #(
  parameter int unsigned CNT_W = 16
) (
  input logic        clk,
  input logic        rst,
  mc_ctrl_if.master  bus
);

  typedef enum logic [3:0] {
    StIdle    = 4'd0,  StFetch  = 4'd1,  StDecode = 4'd2,  StMemAddr = 4'd3,
    StMemRd   = 4'd4,  StMemWb  = 4'd5,  StMemWr  = 4'd6,  StExecR   = 4'd7,
    StWbR     = 4'd8,  StBranch = 4'd9,  StJump   = 4'd10, StExecI   = 4'd11,
    StWbI     = 4'd12, StHalt   = 4'd13
  } state_e;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpAddi  = 6'b001000;

  state_e           r_state;
  state_e           w_next;
  logic             w_retire;
  logic [CNT_W-1:0] r_cnt;
  logic             r_illegal;

  function automatic logic f_legal(input logic [5:0] f);
    case (f)
      6'h20, 6'h22, 6'h24, 6'h25, 6'h2A: f_legal = 1'b1;
      default:                           f_legal = 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] f_alu(input logic [5:0] f);
    case (f)
      6'h22:   f_alu = 3'b110;
      6'h24:   f_alu = 3'b000;
      6'h25:   f_alu = 3'b001;
      6'h2A:   f_alu = 3'b111;
      default: f_alu = 3'b010;
    endcase
  endfunction

  always_comb begin
    w_retire = 1'b0;
    w_next   = r_state;
    case (r_state)
      StIdle:    if (bus.run) w_next = StFetch;
      StFetch:   if (bus.imem_ready) w_next = StDecode;
      StDecode: begin
        case (bus.opcode)
          OpRtype:   w_next = f_legal(bus.funct) ? StExecR : StHalt;
          OpLw, OpSw: w_next = StMemAddr;
          OpBeq:     w_next = StBranch;
          OpJ:       w_next = StJump;
          OpAddi:    w_next = StExecI;
          default:   w_next = StHalt;
        endcase
      end
      StMemAddr: w_next = (bus.opcode == OpLw) ? StMemRd : StMemWr;
      StMemRd:   if (bus.dmem_ready) w_next = StMemWb;
      StMemWr:   w_retire = bus.dmem_ready;
      StExecR:   w_next = StWbR;
      StExecI:   w_next = StWbI;
      StMemWb, StWbR, StBranch, StJump, StWbI: w_retire = 1'b1;
      StHalt:    w_next = StHalt;
      default:   w_next = StHalt;
    endcase
    // run is only consulted at the instruction boundary
    if (w_retire) w_next = bus.run ? StFetch : StIdle;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= StIdle;
      r_cnt     <= '0;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_retire) r_cnt <= r_cnt + 1'b1;
      if (w_next == StHalt) r_illegal <= 1'b1;
    end
  end

  always_comb begin
    bus.imem_req   = 1'b0;
    bus.ir_write   = 1'b0;
    bus.pc_write   = 1'b0;
    bus.pc_src     = 2'b00;
    bus.dmem_read  = 1'b0;
    bus.dmem_write = 1'b0;
    bus.reg_write  = 1'b0;
    bus.reg_dest   = 1'b0;
    bus.mem_to_reg = 1'b0;
    bus.alu_src    = 1'b0;
    bus.alu_ctrl   = 3'b000;
    case (r_state)
      StFetch: begin
        bus.imem_req = 1'b1;
        bus.ir_write = bus.imem_ready;
        bus.pc_write = bus.imem_ready;
      end
      StMemAddr, StExecI: begin
        bus.alu_src  = 1'b1;
        bus.alu_ctrl = 3'b010;
      end
      StMemRd: begin
        bus.dmem_read = 1'b1;
        bus.alu_src   = 1'b1;
        bus.alu_ctrl  = 3'b010;
      end
      StMemWb: begin
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = 1'b1;
      end
      StMemWr: begin
        bus.dmem_write = 1'b1;
        bus.alu_src    = 1'b1;
        bus.alu_ctrl   = 3'b010;
      end
      StExecR:   bus.alu_ctrl = f_alu(bus.funct);
      StWbR: begin
        bus.alu_ctrl  = f_alu(bus.funct);
        bus.reg_write = 1'b1;
        bus.reg_dest  = 1'b1;
      end
      StBranch: begin
        bus.alu_ctrl = 3'b110;
        bus.pc_src   = 2'b01;
        bus.pc_write = bus.eq_zero;
      end
      StJump: begin
        bus.pc_src   = 2'b10;
        bus.pc_write = 1'b1;
      end
      StWbI: begin
        bus.alu_src   = 1'b1;
        bus.alu_ctrl  = 3'b010;
        bus.reg_write = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.state      = r_state;
  assign bus.retire     = w_retire;
  assign bus.retire_cnt = r_cnt;
  assign bus.illegal    = r_illegal;

endmodule

// File: tb/tb_mc_ctrl.sv
// Scoreboard bench for mc_ctrl: the driver queues the expected retire-cycle controls,
// a monitor pops and compares on every retire pulse; the driver checks traces and timing.
module tb_mc_ctrl;
  localparam int unsigned CntW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mc_ctrl_if #(.CNT_W(CntW)) bus ();
  mc_ctrl #(.CNT_W(CntW)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    int             id;
    logic [14:0]    outs;
    logic [CntW-1:0] cnt;
  } exp_t;

  exp_t            sb[$];
  int              errors = 0;
  int              checks = 0;
  logic [CntW-1:0] exp_cnt = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // {state, pc_write, pc_src, reg_write, reg_dest, mem_to_reg, alu_ctrl, dmem_write}
  function automatic logic [14:0] mk(input logic [3:0] st, input logic pcw, input logic [1:0] src,
                                     input logic rw, input logic rd, input logic m2r,
                                     input logic [2:0] alu, input logic dw);
    return {st, pcw, src, rw, rd, m2r, alu, dw};
  endfunction

  task automatic expect_retire(input int id, input logic [14:0] v);
    exp_t e;
    e.id   = id;
    e.outs = v;
    e.cnt  = exp_cnt;
    sb.push_back(e);
    exp_cnt++;
  endtask

  // Monitor: compares the controls presented in each retire cycle.
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (bus.retire === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_retire", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk($sformatf("retire%0d_outs", e.id),
            {17'd0, bus.state, bus.pc_write, bus.pc_src, bus.reg_write, bus.reg_dest,
             bus.mem_to_reg, bus.alu_ctrl, bus.dmem_write}, {17'd0, e.outs});
        chk($sformatf("retire%0d_cnt", e.id), {16'd0, bus.retire_cnt}, {16'd0, e.cnt});
      end
    end
  end

  task automatic do_instr(input logic [5:0] op, input logic [5:0] fn, input int istall,
                          input int dstall, input logic eqz, input int drop_at, input int max_cyc,
                          output int ncyc, output logic [31:0] trace, output int n_dreq,
                          output int n_rw_early, output int n_ireq, output logic retired);
    int wi = 0;
    int wd = 0;
    ncyc = 0; trace = '0; n_dreq = 0; n_rw_early = 0; n_ireq = 0; retired = 1'b0;
    while (!retired && ncyc < max_cyc) begin
      @(negedge clk);
      if (ncyc == 0) begin
        bus.opcode  = op;
        bus.funct   = fn;
        bus.eq_zero = eqz;
      end
      if (ncyc + 1 == drop_at) bus.run = 1'b0;
      if (bus.imem_req) begin
        bus.imem_ready = (wi >= istall);
        wi++;
      end else begin
        bus.imem_ready = 1'b1;
      end
      if (bus.dmem_read || bus.dmem_write) begin
        bus.dmem_ready = (wd >= dstall);
        wd++;
        n_dreq++;
      end else begin
        bus.dmem_ready = 1'b0;
      end
      #1;
      ncyc++;
      trace = {trace[27:0], bus.state};
      if (bus.imem_req) n_ireq++;
      if (bus.reg_write && !bus.retire) n_rw_early++;
      retired = bus.retire;
    end
  endtask

  task automatic do_reset(input string name);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk({name, "_outs"},
        {12'd0, bus.imem_req, bus.ir_write, bus.pc_write, bus.pc_src, bus.dmem_read,
         bus.dmem_write, bus.reg_write, bus.reg_dest, bus.mem_to_reg, bus.alu_src, bus.alu_ctrl,
         bus.state, bus.retire}, 32'd0);
    chk({name, "_cnt"}, {16'd0, bus.retire_cnt}, 32'd0);
    chk({name, "_illegal"}, {31'd0, bus.illegal}, 32'd0);
    exp_cnt = '0;
    rst     = 1'b0;
  endtask

  int          ncyc, n_dreq, n_rw, n_ireq;
  logic [31:0] tr;
  logic        ret;

  task automatic run_ok(input int id, input logic [5:0] op, input logic [5:0] fn, input int istall,
                        input int dstall, input logic eqz, input int drop_at,
                        input logic [14:0] v, input int exp_cyc, input logic [31:0] exp_tr);
    expect_retire(id, v);
    do_instr(op, fn, istall, dstall, eqz, drop_at, 40, ncyc, tr, n_dreq, n_rw, n_ireq, ret);
    chk($sformatf("instr%0d_retired", id), {31'd0, ret}, 32'd1);
    chk($sformatf("instr%0d_cycles", id), ncyc, exp_cyc);
    chk($sformatf("instr%0d_trace", id), tr, exp_tr);
  endtask

  initial begin
    bus.run = 1'b0; bus.opcode = '0; bus.funct = '0; bus.eq_zero = 1'b0;
    bus.imem_ready = 1'b1; bus.dmem_ready = 1'b0;
    do_reset("reset0");
    bus.run = 1'b1;

    run_ok(1, 6'h00, 6'h20, 0, 0, 1'b0, 0, mk(4'd8, 0, 2'b00, 1, 1, 0, 3'b010, 0), 4, 32'h1278);
    run_ok(2, 6'h23, 6'h00, 0, 3, 1'b0, 0, mk(4'd5, 0, 2'b00, 1, 0, 1, 3'b000, 0), 8,
           32'h1234_4445);
    chk("lw_dmem_read_cycles", n_dreq, 4);
    chk("lw_early_reg_write", n_rw, 0);
    run_ok(3, 6'h04, 6'h00, 0, 0, 1'b1, 0, mk(4'd9, 1, 2'b01, 0, 0, 0, 3'b110, 0), 3, 32'h129);
    run_ok(4, 6'h04, 6'h00, 0, 0, 1'b0, 0, mk(4'd9, 0, 2'b01, 0, 0, 0, 3'b110, 0), 3, 32'h129);
    run_ok(5, 6'h00, 6'h22, 2, 0, 1'b0, 0, mk(4'd8, 0, 2'b00, 1, 1, 0, 3'b110, 0), 6,
           32'h11_1278);
    run_ok(6, 6'h00, 6'h24, 0, 0, 1'b0, 0, mk(4'd8, 0, 2'b00, 1, 1, 0, 3'b000, 0), 4, 32'h1278);
    run_ok(7, 6'h00, 6'h25, 0, 0, 1'b0, 0, mk(4'd8, 0, 2'b00, 1, 1, 0, 3'b001, 0), 4, 32'h1278);
    run_ok(8, 6'h00, 6'h2A, 0, 0, 1'b0, 0, mk(4'd8, 0, 2'b00, 1, 1, 0, 3'b111, 0), 4, 32'h1278);
    run_ok(9, 6'h2B, 6'h00, 0, 0, 1'b0, 0, mk(4'd6, 0, 2'b00, 0, 0, 0, 3'b010, 1), 4, 32'h1236);
    run_ok(10, 6'h02, 6'h00, 0, 0, 1'b0, 0, mk(4'd10, 1, 2'b10, 0, 0, 0, 3'b000, 0), 3,
           32'h12A);
    // run dropped while in EXEC_I (cycle 3): WB_I still retires, then IDLE
    run_ok(11, 6'h08, 6'h00, 0, 0, 1'b0, 3, mk(4'd12, 0, 2'b00, 1, 0, 0, 3'b010, 0), 4,
           32'h12BC);
    @(negedge clk);
    #1;
    chk("drop_run_idle_state", {28'd0, bus.state}, 32'd0);
    chk("drop_run_idle_req", {31'd0, bus.imem_req}, 32'd0);
    bus.run = 1'b1;
    run_ok(12, 6'h02, 6'h00, 0, 0, 1'b0, 0, mk(4'd10, 1, 2'b10, 0, 0, 0, 3'b000, 0), 3,
           32'h12A);

    // illegal opcode
    do_instr(6'h3F, 6'h00, 0, 0, 1'b0, 0, 6, ncyc, tr, n_dreq, n_rw, n_ireq, ret);
    chk("illop_retired", {31'd0, ret}, 32'd0);
    chk("illop_trace", tr, 32'h0012_DDDD);
    chk("illop_ireq", n_ireq, 1);
    chk("illop_illegal", {31'd0, bus.illegal}, 32'd1);
    chk("sb_empty_before_reset", sb.size(), 0);
    do_reset("reset1");

    // illegal funct
    do_instr(6'h00, 6'h01, 0, 0, 1'b0, 0, 6, ncyc, tr, n_dreq, n_rw, n_ireq, ret);
    chk("illfn_retired", {31'd0, ret}, 32'd0);
    chk("illfn_trace", tr, 32'h0012_DDDD);
    chk("illfn_ireq", n_ireq, 1);
    chk("illfn_illegal", {31'd0, bus.illegal}, 32'd1);
    do_reset("reset2");

    // retire once so the counter is non-zero, then reset mid sw wait
    run_ok(13, 6'h02, 6'h00, 0, 0, 1'b0, 0, mk(4'd10, 1, 2'b10, 0, 0, 0, 3'b000, 0), 3,
           32'h12A);
    do_instr(6'h2B, 6'h00, 0, 10, 1'b0, 0, 5, ncyc, tr, n_dreq, n_rw, n_ireq, ret);
    chk("sw_wait_trace", tr, 32'h0001_2366);
    chk("sw_wait_dwrite", {31'd0, bus.dmem_write}, 32'd1);
    chk("sw_wait_cnt", {16'd0, bus.retire_cnt}, 32'd1);
    bus.run = 1'b0;
    do_reset("reset3");

    repeat (2) @(negedge clk);
    chk("sb_empty_at_end", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
